// File: rtl/mcs8_pkg.sv
// Shared types and helpers for the MCS8 instruction-fetch front end.
// Redirect opcodes, instruction-length decode and the decode-stage bundle.
package mcs8_pkg;

    typedef enum logic [1:0] {
        REDIR_JMP  = 2'd0,
        REDIR_CALL = 2'd1,
        REDIR_RET  = 2'd2,
        REDIR_RSVD = 2'd3
    } redir_op_t;

    // Bundle PC field is sized for the widest supported address bus.
    localparam int PC_W = 16;

    typedef struct packed {
        logic [7:0]      op;
        logic [7:0]      b2;
        logic [7:0]      b3;
        logic [1:0]      len;
        logic [PC_W-1:0] pc;
    } fetch_bundle_t;

    function automatic logic [1:0] instr_len(input logic [7:0] op);
        if (op[7:6] == 2'b00 && (op[2:0] == 3'b110 || op[2:0] == 3'b100))
            return 2'd2;
        else if (op[7:6] == 2'b01 && !op[0])
            return 2'd3;
        return 2'd1;
    endfunction

endpackage

// File: rtl/mcs8_prefetch_fifo.sv
// Prefetch byte FIFO: each entry carries a ROM byte and its address.
// Single push, pop of 0..3 bytes per cycle, synchronous flush.
module mcs8_prefetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 14
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [7:0]              push_dat_i,
    input  logic [ADDR_W-1:0]       push_addr_i,
    input  logic [1:0]              pop_n_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [7:0]              b0_o,
    output logic [7:0]              b1_o,
    output logic [7:0]              b2_o,
    output logic [ADDR_W-1:0]       addr0_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]        dat_q [DEPTH];
    logic [ADDR_W-1:0] adr_q [DEPTH];
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W-1:0]  rd_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_q <= '{default: '0};
            adr_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                dat_q[wr_q] <= push_dat_i;
                adr_q[wr_q] <= push_addr_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            rd_q  <= rd_q + PTR_W'(pop_n_i);
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_n_i);
        end
    end

    assign count_o = cnt_q;
    assign b0_o    = dat_q[rd_q];
    assign b1_o    = dat_q[rd_q + PTR_W'(1)];
    assign b2_o    = dat_q[rd_q + PTR_W'(2)];
    assign addr0_o = adr_q[rd_q];

endmodule

// File: rtl/mcs8_fetch_unit.sv
// MCS8 fetch front end: PC/return stack, ROM request issue, prefetch FIFO
// and 1..3 byte instruction assembly towards decode over valid/ready.
module mcs8_fetch_unit
    import mcs8_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int STACK_DEPTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           CLK_I,
    input  logic                           RST_I,
    output logic [ADDR_W-1:0]              I_ADDR_O,
    input  logic [7:0]                     I_DAT_I,
    input  logic                           HALT_I,
    input  logic                           REDIR_VALID_I,
    input  logic [1:0]                     REDIR_OP_I,
    input  logic [ADDR_W-1:0]              REDIR_ADDR_I,
    input  logic [ADDR_W-1:0]              RET_ADDR_I,
    output logic                           IV_O,
    input  logic                           IR_I,
    output logic [7:0]                     OP_O,
    output logic [7:0]                     B2_O,
    output logic [7:0]                     B3_O,
    output logic [1:0]                     LEN_O,
    output logic [ADDR_W-1:0]              PC_O,
    output logic [$clog2(STACK_DEPTH)-1:0] SP_O,
    output logic                           STK_OVF_O,
    output logic                           STK_UNF_O
);

    localparam int SP_W  = $clog2(STACK_DEPTH);
    localparam int SC_W  = SP_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
    logic [SP_W-1:0]   idx_q;
    logic [SC_W-1:0]   calls_q;
    logic              ovf_q;
    logic              unf_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              iv_q;
    fetch_bundle_t     bndl_q;
    fetch_bundle_t     bndl_d;

    redir_op_t         rop;
    logic              redir;
    logic [ADDR_W-1:0] pc;
    logic              issue;
    logic              can_load;
    logic [1:0]        head_len;
    logic [1:0]        pop_n;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [7:0]        fifo_b0;
    logic [7:0]        fifo_b1;
    logic [7:0]        fifo_b2;
    logic [ADDR_W-1:0] fifo_addr0;
    logic              unused_pc_bits;

    assign rop      = redir_op_t'(REDIR_OP_I);
    assign redir    = REDIR_VALID_I && (rop != REDIR_RSVD);
    assign pc       = stk_q[idx_q];
    assign issue    = !HALT_I && !redir &&
                      ((fifo_cnt + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
    assign head_len = instr_len(fifo_b0);
    assign can_load = !redir && (!iv_q || IR_I) && (fifo_cnt != '0) &&
                      (fifo_cnt >= CNT_W'(head_len));
    assign pop_n    = can_load ? head_len : 2'd0;

    // A redirect flushes the FIFO; flush beats the push, which drops the
    // in-flight byte arriving on that same edge.
    mcs8_prefetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i       (CLK_I),
        .rst_i       (RST_I),
        .flush_i     (redir),
        .push_i      (inflight_q),
        .push_dat_i  (I_DAT_I),
        .push_addr_i (req_addr_q),
        .pop_n_i     (pop_n),
        .count_o     (fifo_cnt),
        .b0_o        (fifo_b0),
        .b1_o        (fifo_b1),
        .b2_o        (fifo_b2),
        .addr0_o     (fifo_addr0)
    );

    always_comb begin
        bndl_d     = '0;
        bndl_d.op  = fifo_b0;
        bndl_d.b2  = (head_len >= 2'd2) ? fifo_b1 : 8'h00;
        bndl_d.b3  = (head_len == 2'd3) ? fifo_b2 : 8'h00;
        bndl_d.len = head_len;
        bndl_d.pc  = PC_W'(fifo_addr0);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            stk_q      <= '{default: '0};
            idx_q      <= '0;
            calls_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_addr_q   <= pc;
                stk_q[idx_q] <= pc + ADDR_W'(1);
            end
            if (redir) begin
                case (rop)
                    REDIR_JMP: stk_q[idx_q] <= REDIR_ADDR_I;
                    REDIR_CALL: begin
                        stk_q[idx_q]           <= RET_ADDR_I;
                        stk_q[idx_q + SP_W'(1)] <= REDIR_ADDR_I;
                        idx_q                  <= idx_q + SP_W'(1);
                        if (calls_q == SC_W'(STACK_DEPTH))
                            ovf_q <= 1'b1;
                        else
                            calls_q <= calls_q + SC_W'(1);
                    end
                    REDIR_RET: begin
                        idx_q <= idx_q - SP_W'(1);
                        if (calls_q == '0)
                            unf_q <= 1'b1;
                        else
                            calls_q <= calls_q - SC_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            iv_q   <= 1'b0;
            bndl_q <= '0;
        end else if (redir) begin
            iv_q <= 1'b0;
        end else if (!iv_q || IR_I) begin
            iv_q <= can_load;
            if (can_load)
                bndl_q <= bndl_d;
        end
    end

    assign unused_pc_bits = ^bndl_q.pc;

    assign I_ADDR_O  = pc;
    assign IV_O      = iv_q;
    assign OP_O      = bndl_q.op;
    assign B2_O      = bndl_q.b2;
    assign B3_O      = bndl_q.b3;
    assign LEN_O     = bndl_q.len;
    assign PC_O      = bndl_q.pc[ADDR_W-1:0];
    assign SP_O      = idx_q;
    assign STK_OVF_O = ovf_q;
    assign STK_UNF_O = unf_q;

endmodule

// File: tb/tb_mcs8_fetch_unit.sv
// Bench for mcs8_fetch_unit: synchronous ROM model, directed stimulus,
// expected bundles queued by stimulus and checked by a separate monitor.
module tb_mcs8_fetch_unit;

    localparam int AW = 14;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b1;
    logic [AW-1:0] I_ADDR_O;
    logic [7:0]    I_DAT_I;
    logic          HALT_I = 1'b0;
    logic          REDIR_VALID_I = 1'b0;
    logic [1:0]    REDIR_OP_I = 2'd0;
    logic [AW-1:0] REDIR_ADDR_I = '0;
    logic [AW-1:0] RET_ADDR_I = '0;
    logic          IV_O;
    logic          IR_I = 1'b0;
    logic [7:0]    OP_O, B2_O, B3_O;
    logic [1:0]    LEN_O;
    logic [AW-1:0] PC_O;
    logic [2:0]    SP_O;
    logic          STK_OVF_O, STK_UNF_O;

    always #5 CLK_I = ~CLK_I;

    logic [7:0] rom [0:16383];
    logic [7:0] rom_q = 8'h00;
    always @(posedge CLK_I) rom_q <= rom[I_ADDR_O];
    assign I_DAT_I = rom_q;

    mcs8_fetch_unit #(.ADDR_W(AW), .STACK_DEPTH(8), .FIFO_DEPTH(4)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .I_ADDR_O(I_ADDR_O), .I_DAT_I(I_DAT_I),
        .HALT_I(HALT_I), .REDIR_VALID_I(REDIR_VALID_I), .REDIR_OP_I(REDIR_OP_I),
        .REDIR_ADDR_I(REDIR_ADDR_I), .RET_ADDR_I(RET_ADDR_I), .IV_O(IV_O),
        .IR_I(IR_I), .OP_O(OP_O), .B2_O(B2_O), .B3_O(B3_O), .LEN_O(LEN_O),
        .PC_O(PC_O), .SP_O(SP_O), .STK_OVF_O(STK_OVF_O), .STK_UNF_O(STK_UNF_O)
    );

    typedef struct packed {
        logic [7:0]    op;
        logic [7:0]    b2;
        logic [7:0]    b3;
        logic [1:0]    len;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_b(input logic [7:0] op, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [1:0] len, input logic [AW-1:0] pc);
        expq.push_back({op, b2, b3, len, pc});
    endtask

    // Monitor: every handshake (IV_O && IR_I at the next edge) pops one expectation.
    always @(negedge CLK_I) begin : monitor
        exp_t e;
        exp_t got;
        if (!RST_I && IV_O && IR_I) begin
            hs_cnt++;
            got = {OP_O, B2_O, B3_O, LEN_O, PC_O};
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bundle: got op=%h pc=%h, expected none", OP_O, PC_O);
            end else begin
                e = expq.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL bundle: got op=%h b2=%h b3=%h len=%0d pc=%h, expected op=%h b2=%h b3=%h len=%0d pc=%h",
                             OP_O, B2_O, B3_O, LEN_O, PC_O, e.op, e.b2, e.b3, e.len, e.pc);
                end
            end
        end
    end

    task automatic rom_clear();
        for (int i = 0; i < 16384; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset(input logic ir);
        RST_I = 1'b1;
        IR_I = ir;
        HALT_I = 1'b0;
        REDIR_VALID_I = 1'b0;
        expq.delete();
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
    endtask

    task automatic accept_n(input int n);
        int target;
        int t;
        target = hs_cnt + n;
        t = 0;
        IR_I = 1'b1;
        while (hs_cnt < target && t < 200) begin
            @(posedge CLK_I);
            #1;
            t++;
        end
        IR_I = 1'b0;
        if (hs_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got %0d handshakes, expected %0d", hs_cnt, target);
        end
    endtask

    task automatic redirect(input logic [1:0] op, input logic [AW-1:0] tgt, input logic [AW-1:0] ret);
        REDIR_VALID_I = 1'b1;
        REDIR_OP_I = op;
        REDIR_ADDR_I = tgt;
        RET_ADDR_I = ret;
        @(posedge CLK_I);
        #1;
        REDIR_VALID_I = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        rom_clear();

        // 1-byte opcodes from reset: first IV_O after edge 3, then one per cycle.
        rom[0] = 8'hC0; rom[1] = 8'hC1; rom[2] = 8'hC2;
        do_reset(1'b1);
        check("reset_iv", IV_O, 0);
        check("reset_addr", I_ADDR_O, 0);
        check("reset_sp", SP_O, 0);
        expect_b(8'hC0, 8'h00, 8'h00, 2'd1, 14'h0000);
        expect_b(8'hC1, 8'h00, 8'h00, 2'd1, 14'h0001);
        expect_b(8'hC2, 8'h00, 8'h00, 2'd1, 14'h0002);
        @(posedge CLK_I);
        @(posedge CLK_I);
        @(negedge CLK_I);
        check("iv_before_edge3", IV_O, 0);
        @(posedge CLK_I);
        #1;
        h0 = hs_cnt;
        @(negedge CLK_I);
        check("iv_at_edge3", IV_O, 1);
        repeat (3) @(posedge CLK_I);
        #1;
        check("back_to_back", hs_cnt - h0, 3);
        IR_I = 1'b0;
        cycles(2);
        check("t1_drain", expq.size(), 0);

        // Mixed 2- and 3-byte instructions.
        rom_clear();
        rom[0] = 8'h06; rom[1] = 8'h55; rom[2] = 8'h44; rom[3] = 8'h34; rom[4] = 8'h12;
        do_reset(1'b0);
        expect_b(8'h06, 8'h55, 8'h00, 2'd2, 14'h0000);
        expect_b(8'h44, 8'h34, 8'h12, 2'd3, 14'h0002);
        accept_n(2);
        check("t2_drain", expq.size(), 0);

        // Backpressure: bundle held, FIFO full, issue stalls at address 5.
        rom_clear();
        for (int i = 0; i < 16; i++) rom[i] = 8'hC0 + 8'(i);
        do_reset(1'b0);
        cycles(10);
        check("hold_iv", IV_O, 1);
        check("hold_pc", PC_O, 0);
        check("full_addr", I_ADDR_O, 5);
        cycles(3);
        check("full_addr_again", I_ADDR_O, 5);
        check("hold_op", OP_O, 8'hC0);
        for (int i = 0; i < 6; i++) expect_b(8'hC0 + 8'(i), 8'h00, 8'h00, 2'd1, AW'(i));
        accept_n(6);
        check("t3_drain", expq.size(), 0);

        // CALL then RET: stale prefetched bytes must never reach decode.
        for (int i = 0; i < 8; i++) rom[14'h100 + i] = 8'hD0 + 8'(i);
        do_reset(1'b0);
        expect_b(8'hC0, 8'h00, 8'h00, 2'd1, 14'h0000);
        expect_b(8'hC1, 8'h00, 8'h00, 2'd1, 14'h0001);
        accept_n(2);
        cycles(4);
        redirect(2'd1, 14'h0100, 14'h0005);
        check("call_addr", I_ADDR_O, 14'h0100);
        check("call_sp", SP_O, 1);
        expect_b(8'hD0, 8'h00, 8'h00, 2'd1, 14'h0100);
        expect_b(8'hD1, 8'h00, 8'h00, 2'd1, 14'h0101);
        accept_n(2);
        cycles(3);
        redirect(2'd2, 14'h0000, 14'h0000);
        check("ret_sp", SP_O, 0);
        check("ret_addr", I_ADDR_O, 14'h0005);
        check("ret_no_unf", STK_UNF_O, 0);
        expect_b(8'hC5, 8'h00, 8'h00, 2'd1, 14'h0005);
        expect_b(8'hC6, 8'h00, 8'h00, 2'd1, 14'h0006);
        accept_n(2);
        check("t4_drain", expq.size(), 0);

        // Redirect while halted, then stack overflow / underflow.
        do_reset(1'b0);
        HALT_I = 1'b1;
        redirect(2'd0, 14'h0123, 14'h0000);
        cycles(3);
        check("halt_jmp_addr", I_ADDR_O, 14'h0123);
        check("halt_iv", IV_O, 0);
        HALT_I = 1'b0;
        for (int i = 0; i < 8; i++) redirect(2'd1, AW'(14'h200 + i), AW'(14'h10 + i));
        check("eight_calls_sp", SP_O, 0);
        check("eight_calls_ovf", STK_OVF_O, 0);
        redirect(2'd1, 14'h0300, 14'h0020);
        check("ninth_call_sp", SP_O, 1);
        check("ninth_call_ovf", STK_OVF_O, 1);
        check("ninth_call_unf", STK_UNF_O, 0);
        do_reset(1'b0);
        check("flags_reset_ovf", STK_OVF_O, 0);
        redirect(2'd2, 14'h0000, 14'h0000);
        check("unf_sp", SP_O, 7);
        check("unf_flag", STK_UNF_O, 1);
        check("unf_no_ovf", STK_OVF_O, 0);

        // Address wrap at the top of the space, then asynchronous reset.
        rom_clear();
        rom[14'h3FFE] = 8'hC7; rom[14'h3FFF] = 8'hC8; rom[0] = 8'hC9;
        do_reset(1'b0);
        cycles(3);
        redirect(2'd0, 14'h3FFE, 14'h0000);
        check("jmp_addr", I_ADDR_O, 14'h3FFE);
        expect_b(8'hC7, 8'h00, 8'h00, 2'd1, 14'h3FFE);
        expect_b(8'hC8, 8'h00, 8'h00, 2'd1, 14'h3FFF);
        expect_b(8'hC9, 8'h00, 8'h00, 2'd1, 14'h0000);
        accept_n(3);
        check("t6_drain", expq.size(), 0);
        cycles(3);
        check("pre_rst_iv", IV_O, 1);
        @(negedge CLK_I);
        #1;
        RST_I = 1'b1;
        #1;
        check("async_rst_iv", IV_O, 0);
        check("async_rst_addr", I_ADDR_O, 0);
        check("async_rst_sp", SP_O, 0);
        cycles(2);
        RST_I = 1'b0;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
